// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS core.
// Optional HAZARD_STAT_EN adds stall_cnt/fwd_cnt statistics ports.
module hazard_fwd_ctrl #(
  parameter int         SEL_W  = 3,
  parameter logic [4:0] RA_REG = 5'd31
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      ir_d,
  output logic             stall,
  output logic [SEL_W-1:0] sel_rsd,
  output logic [SEL_W-1:0] sel_rtd,
  output logic [SEL_W-1:0] sel_rse,
  output logic [SEL_W-1:0] sel_rte,
  output logic [SEL_W-1:0] sel_rtm
`ifdef HAZARD_STAT_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      fwd_cnt
`endif
);

  typedef struct packed {
    logic       valid;
    logic       jal;
    logic [4:0] dst;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
  } slot_t;

  slot_t e_q, m_q, w_q, dec;

  logic [5:0] op, funct;
  logic [4:0] rs_f, rt_f, rd_f;
  logic       is_r, is_alu, is_imm, is_lw, is_sw;
  logic       is_beq, is_jal, is_jr;
  logic       rs_rd, rt_rd;
  logic [1:0] tuse_rs, tuse_rt;

  assign op    = ir_d[31:26];
  assign rs_f  = ir_d[25:21];
  assign rt_f  = ir_d[20:16];
  assign rd_f  = ir_d[15:11];
  assign funct = ir_d[5:0];

  assign is_r   = (op == 6'h00) && (ir_d[10:6] == 5'd0);
  assign is_alu = is_r && (funct == 6'h21 || funct == 6'h23);
  assign is_jr  = is_r && (funct == 6'h08);
  assign is_imm = (op == 6'h0D) || (op == 6'h0F);
  assign is_lw  = (op == 6'h23);
  assign is_sw  = (op == 6'h2B);
  assign is_beq = (op == 6'h04);
  assign is_jal = (op == 6'h03);

  always_comb begin
    dec     = '0;
    rs_rd   = 1'b0;
    rt_rd   = 1'b0;
    tuse_rs = 2'd0;
    tuse_rt = 2'd0;
    unique case (1'b1)
      is_alu: begin
        dec.valid = 1'b1;
        dec.dst   = rd_f;
        dec.tnew  = 2'd1;
        rs_rd     = 1'b1;
        rt_rd     = 1'b1;
        tuse_rs   = 2'd1;
        tuse_rt   = 2'd1;
      end
      is_imm: begin
        dec.valid = 1'b1;
        dec.dst   = rt_f;
        dec.tnew  = 2'd1;
        rs_rd     = 1'b1;
        tuse_rs   = 2'd1;
      end
      is_lw: begin
        dec.valid = 1'b1;
        dec.dst   = rt_f;
        dec.tnew  = 2'd2;
        rs_rd     = 1'b1;
        tuse_rs   = 2'd1;
      end
      is_sw: begin
        dec.valid = 1'b1;
        rs_rd     = 1'b1;
        rt_rd     = 1'b1;
        tuse_rs   = 2'd1;
        tuse_rt   = 2'd2;
      end
      is_beq: begin
        dec.valid = 1'b1;
        rs_rd     = 1'b1;
        rt_rd     = 1'b1;
      end
      is_jr: begin
        dec.valid = 1'b1;
        rs_rd     = 1'b1;
      end
      is_jal: begin
        dec.valid = 1'b1;
        dec.jal   = 1'b1;
        dec.dst   = RA_REG;
      end
      default: ;
    endcase
    if (dec.dst == 5'd0) dec.tnew = 2'd0;
    dec.rs = rs_rd ? rs_f : 5'd0;
    dec.rt = rt_rd ? rt_f : 5'd0;
  end

  // Result {hit, tnew, code}; the nearest enabled match wins even when not ready.
  function automatic logic [5:0] look(
    input logic [4:0] a,
    input slot_t      s0,
    input slot_t      s1,
    input slot_t      s2,
    input logic [2:0] en
  );
    logic [5:0] r;
    r = '0;
    if (a != 5'd0) begin
      if (en[0] && s0.valid && s0.dst == a)
        r = {1'b1, s0.tnew, (s0.tnew == 2'd0) ? 3'd1 : 3'd0};
      else if (en[1] && s1.valid && s1.dst == a)
        r = {1'b1, s1.tnew,
             (s1.tnew != 2'd0) ? 3'd0 : (s1.jal ? 3'd3 : 3'd2)};
      else if (en[2] && s2.valid && s2.dst == a)
        r = {1'b1, s2.tnew, (s2.tnew == 2'd0) ? 3'd4 : 3'd0};
    end
    return r;
  endfunction

  function automatic slot_t age(input slot_t s);
    slot_t r;
    r = s;
    if (r.tnew != 2'd0) r.tnew = r.tnew - 2'd1;
    return r;
  endfunction

  logic [5:0] l_rsd, l_rtd, l_rse, l_rte, l_rtm;

  assign l_rsd = look(dec.rs, e_q, m_q, w_q, 3'b111);
  assign l_rtd = look(dec.rt, e_q, m_q, w_q, 3'b111);
  assign l_rse = look(e_q.rs, e_q, m_q, w_q, 3'b110);
  assign l_rte = look(e_q.rt, e_q, m_q, w_q, 3'b110);
  assign l_rtm = look(m_q.rt, e_q, m_q, w_q, 3'b100);

  assign stall = (l_rsd[5] && l_rsd[4:3] > tuse_rs)
               | (l_rtd[5] && l_rtd[4:3] > tuse_rt);

  assign sel_rsd = SEL_W'(l_rsd[2:0]);
  assign sel_rtd = SEL_W'(l_rtd[2:0]);
  assign sel_rse = SEL_W'(l_rse[2:0]);
  assign sel_rte = SEL_W'(l_rte[2:0]);
  assign sel_rtm = SEL_W'(l_rtm[2:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      w_q <= age(m_q);
      m_q <= age(e_q);
      e_q <= stall ? '0 : dec;
    end
  end

`ifdef HAZARD_STAT_EN
  logic any_fwd;
  assign any_fwd = |{sel_rsd, sel_rtd, sel_rse, sel_rte, sel_rtm};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall)   stall_cnt <= stall_cnt + 32'd1;
      if (any_fwd) fwd_cnt   <= fwd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench for hazard_fwd_ctrl: hand-derived expectations
// queued per D-stage instruction and compared mid-cycle.
module tb_hazard_fwd_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] A1  = 32'h0022_1821;
  localparam logic [31:0] A2  = 32'h0063_2021;
  localparam logic [31:0] L5  = 32'h8C05_0000;
  localparam logic [31:0] U5  = 32'h00A0_3021;
  localparam logic [31:0] B5  = 32'h10A0_0000;
  localparam logic [31:0] JAL = 32'h0C00_0000;
  localparam logic [31:0] JR  = 32'h03E0_0008;
  localparam logic [31:0] L7  = 32'h8C07_0000;
  localparam logic [31:0] S7  = 32'hAC07_0000;
  localparam logic [31:0] L0  = 32'h8C00_0000;
  localparam logic [31:0] U0  = 32'h0000_3021;
  localparam logic [15:0] Z   = 16'h0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] ir_d = 32'h0;
  logic        stall;
  logic [2:0]  sel_rsd, sel_rtd, sel_rse, sel_rte, sel_rtm;
`ifdef HAZARD_STAT_EN
  logic [31:0] stall_cnt, fwd_cnt;
`endif

  hazard_fwd_ctrl dut (
    .clk(clk),
    .reset_n(reset_n),
    .ir_d(ir_d),
    .stall(stall),
    .sel_rsd(sel_rsd),
    .sel_rtd(sel_rtd),
    .sel_rse(sel_rse),
    .sel_rte(sel_rte),
    .sel_rtm(sel_rtm)
`ifdef HAZARD_STAT_EN
    ,
    .stall_cnt(stall_cnt),
    .fwd_cnt(fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs;

  assign obs = {stall, sel_rsd, sel_rtd, sel_rse, sel_rte, sel_rtm};

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got={stall,rsd,rtd,rse,rte,rtm}=%h want=%h",
               tag, got, want);
    end
  endtask

  function automatic logic [15:0] pk(input int s, input int a,
                                     input int b, input int c,
                                     input int d, input int f);
    return {s[0], a[2:0], b[2:0], c[2:0], d[2:0], f[2:0]};
  endfunction

  task automatic step(input string tag, input logic [31:0] ir,
                      input logic [15:0] want);
    @(negedge clk);
    ir_d = ir;
    exp_q.push_back(want);
    #2;
    check(tag, obs, exp_q.pop_front());
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) step("flush", NOP, Z);
  endtask

  initial begin
    #12;
    exp_q.push_back(Z);
    check("reset", obs, exp_q.pop_front());
    @(negedge clk);
    reset_n = 1'b1;
    flush();

    step("alu_a1", A1, Z);
    step("alu_a2_d", A2, Z);
    step("alu_a2_e", NOP, pk(0, 0, 0, 2, 2, 0));
    step("alu_a2_m", NOP, pk(0, 0, 0, 0, 0, 4));
    flush();

    step("lu_lw", L5, Z);
    step("lu_stall", U5, pk(1, 0, 0, 0, 0, 0));
    step("lu_held", U5, Z);
    step("lu_e", NOP, pk(0, 0, 0, 4, 0, 0));
    step("lu_m", NOP, Z);
    flush();

    step("lb_lw", L5, Z);
    step("lb_stall1", B5, pk(1, 0, 0, 0, 0, 0));
    step("lb_stall2", B5, pk(1, 0, 0, 0, 0, 0));
    step("lb_fwd", B5, pk(0, 4, 0, 0, 0, 0));
    step("lb_e", NOP, Z);
    flush();

    step("jj_jal", JAL, Z);
    step("jj_jr", JR, pk(0, 1, 0, 0, 0, 0));
    step("jj_e", NOP, pk(0, 0, 0, 3, 0, 0));
    flush();

    step("jnj_jal", JAL, Z);
    step("jnj_nop", NOP, Z);
    step("jnj_jr", JR, pk(0, 3, 0, 0, 0, 0));
    step("jnj_e", NOP, pk(0, 0, 0, 4, 0, 0));
    flush();

    step("ls_lw", L7, Z);
    step("ls_sw_d", S7, Z);
    step("ls_sw_e", NOP, Z);
    step("ls_sw_m", NOP, pk(0, 0, 0, 0, 0, 4));
    flush();

    step("r0_lw", L0, Z);
    step("r0_use", U0, Z);
    step("r0_e", NOP, Z);
    flush();

    step("rst_lw", L5, Z);
    step("rst_dep", U5, pk(1, 0, 0, 0, 0, 0));
    #1 reset_n = 1'b0;
    #1;
    exp_q.push_back(Z);
    check("rst_async", obs, exp_q.pop_front());
    @(negedge clk);
    reset_n = 1'b1;
    ir_d = U5;
    exp_q.push_back(Z);
    #2;
    check("rst_after", obs, exp_q.pop_front());
    step("rst_e", NOP, Z);
    flush();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Pipeline hazard and forwarding controller for the 5-stage MIPS core (F/D/E/M/W).
- It generates the 3-bit select codes consumed by the forwarding muxes at D (rs, rt), E (rs, rt) and M (rt), and the D-stage stall.
- It keeps its own shadow scoreboard of in-flight destinations and Tnew countdowns, advanced every clock.
- The datapath holds F/D on stall; this block inserts the E bubble itself.

Parameters:
- SEL_W, 3, width of every select output.
- RA_REG, 31, destination register written by jal.

Ports:
- clk, input, 1, pipeline clock.
- reset_n, input, 1, asynchronous active-low reset.
- ir_d, input, 32, instruction currently in D.
- stall, output, 1, hold F/D and bubble E.
- sel_rsd, output, SEL_W, D-stage rs forward select.
- sel_rtd, output, SEL_W, D-stage rt forward select.
- sel_rse, output, SEL_W, E-stage rs forward select.
- sel_rte, output, SEL_W, E-stage rt forward select.
- sel_rtm, output, SEL_W, M-stage rt forward select.

Behaviour:
- Clocking and reset: single clock domain. Reset is asynchronous and active-low.
- Select encoding:
  - 0 = register-file / pipeline-register value (no forward)
  - 1 = pc8_e
  - 2 = aluout_m
  - 3 = pc8_m
  - 4 = rf write data at W
  - 5-7 are unused and never driven.
- Decode of ir_d:
  - Supported: addu (op 0, funct 0x21), subu (op 0, funct 0x23), ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, jal 0x03, jr (op 0, funct 0x08).
  - Anything else is treated as no read, no write.
- Destination: rd for addu/subu; rt for ori/lui/lw; RA_REG for jal; none otherwise. A destination of $0 counts as none.
- Tnew at entry to E: lw 2; addu/subu/ori/lui 1; jal 0.
- Tuse rs: beq/jr 0; addu/subu/ori/lui/lw/sw 1.
- Tuse rt: beq 0; addu/subu 1; sw 2.
- Scoreboard slots E, M, W each hold {valid, dst[4:0], tnew[1:0], rs[4:0], rt[4:0]}.
- Each rising clk:
  - W <= M and M <= E, with tnew decremented (saturating at 0) on each move.
  - If stall=1, E <= bubble (valid=0, dst=0).
  - Otherwise E <= decode(ir_d).
- Stall (combinational): for each D operand with nonzero address and a defined Tuse:
  - Find the nearest valid slot (E, then M, then W) whose dst matches.
  - stall=1 if that slot's tnew > Tuse.
  - stall is the OR over rs and rt.
- D-stage forwarding: the nearest matching slot with tnew==0 supplies the value.
  - E slot: only jal can match with tnew 0 -> 1.
  - M slot: jal -> 3, else 2.
  - W slot: -> 4.
  - No match -> 0.
  - A nearer match with tnew>0 blocks forwarding from older slots. Stall covers this case; the select still reports the nearer slot's code or 0.
- E-stage forwarding: compare E.rs/E.rt against M, then W, with the same rules.
- M-stage forwarding: compare M.rt against W only -> 4, else 0.
- Register $0 never forwards and never stalls.
- All outputs are combinational from the scoreboard and ir_d; the scoreboard is updated 1 cycle later.
- Reset (including mid-operation): all slots valid=0, dst=0, tnew=0, so stall=0 and all selects are 0 immediately and asynchronously. The first post-reset instruction in D sees an empty pipeline.

Optional Feature:
- Macro HAZARD_STAT_EN.
- When defined:
  - Adds output port stall_cnt [31:0]: increments on each clk where stall=1, wraps at 2^32, resets to 0.
  - Adds output fwd_cnt [31:0]: increments on clocks where any select is nonzero.
- When undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- addu $3,$1,$2 (0x00221821) then addu $4,$3,$3 (0x00632021) -> no stall; the cycle the second instruction is in E: sel_rse=2, sel_rte=2.
- lw $5,0($0) (0x8C050000) then addu $6,$5,$0 (0x00A03021) -> stall=1 for exactly 1 cycle; E gets a bubble; then in E sel_rse=4.
- lw $5,0($0) then beq $5,$0 (0x10A00000) -> stall=1 for 2 consecutive cycles, then sel_rsd=4.
- jal (0x0C000000) then jr $31 (0x03E00008) -> no stall, sel_rsd=1; if a nop is inserted between, sel_rsd=3.
- lw $7,0($0) then sw $7,0($0) (0xAC070000) -> no stall, sel_rte=0 in E, sel_rtm=4 in M.
- Assert reset_n low while lw is in E with a dependent instruction in D -> stall and all selects drop to 0 without a clock edge; after release, the dependent instruction sees no hazard.
